// File: rtl/weight_update_sequencer.sv
// Time-shared weight-update sequencer: walks every output-layer weight through
// a read / present-to-datapath / write-back cycle, one neuron delta at a time.
module weight_update_sequencer #(
   parameter int N_OUT     = 3,
   parameter int N_HID     = 5,
   parameter int W         = 10,
   parameter int ADDR_W    = 7,
   parameter int BASE_ADDR = 50,
   parameter int SKIP_ZERO = 1,
   localparam int NW       = (N_OUT > 1) ? $clog2(N_OUT) : 1,
   localparam int HW       = (N_HID > 1) ? $clog2(N_HID) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic signed [W-1:0] i_delta_in,
   input  logic                i_sign_in,
   output logic [NW-1:0]       o_neuron_sel,
   output logic [HW-1:0]       o_hid_sel,
   output logic [ADDR_W-1:0]   o_ram_addr,
   output logic                o_ram_re,
   input  logic signed [W-1:0] i_ram_rdata,
   output logic                o_ram_we,
   output logic signed [W-1:0] o_ram_wdata,
   output logic signed [W-1:0] o_upd_weight_old,
   output logic signed [W-1:0] o_upd_delta,
   output logic                o_upd_sign,
   input  logic signed [W-1:0] i_upd_weight_new,
   output logic                o_busy,
   output logic                o_done,
   output logic [7:0]          o_update_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_RD,
      S_UPD,
      S_WR,
      S_FIN
   } state_t;

   localparam logic [NW-1:0]     LAST_N  = NW'(N_OUT - 1);
   localparam logic [HW-1:0]     LAST_H  = HW'(N_HID - 1);
   localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(N_HID);

   state_t              r_state;
   state_t              w_next;
   logic [NW-1:0]       r_n;
   logic [HW-1:0]       r_h;
   logic signed [W-1:0] r_upd_weight_old;
   logic signed [W-1:0] r_upd_delta;
   logic                r_upd_sign;
   logic [7:0]          r_update_count;
   logic                w_skip;
   logic                w_last_n;
   logic                w_last_h;
   logic [ADDR_W-1:0]   w_addr;

   assign w_skip   = (SKIP_ZERO != 0) && (i_delta_in == '0);
   assign w_last_n = (r_n == LAST_N);
   assign w_last_h = (r_h == LAST_H);
   assign w_addr   = BASE_A + ADDR_W'(r_n) * ROW_LEN + ADDR_W'(r_h);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Abort cancels LATCH/RD/UPD outright; in WR the strobe is already out, so it only redirects to IDLE.
   always_comb begin
      w_next         = r_state;
      o_ram_re       = 1'b0;
      o_ram_we       = 1'b0;
      o_ram_addr     = '0;
      o_ram_wdata    = '0;
      o_busy         = 1'b0;
      o_done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               w_next = S_LATCH;
            end
         end
         S_LATCH: begin
            o_busy = 1'b1;
            if (i_abort) begin
               w_next = S_IDLE;
            end else if (w_skip) begin
               w_next = w_last_n ? S_FIN : S_LATCH;
            end else begin
               w_next = S_RD;
            end
         end
         S_RD: begin
            o_busy     = 1'b1;
            o_ram_re   = 1'b1;
            o_ram_addr = w_addr;
            w_next     = i_abort ? S_IDLE : S_UPD;
         end
         S_UPD: begin
            o_busy = 1'b1;
            w_next = i_abort ? S_IDLE : S_WR;
         end
         S_WR: begin
            o_busy      = 1'b1;
            o_ram_we    = 1'b1;
            o_ram_addr  = w_addr;
            o_ram_wdata = i_upd_weight_new;
            if (i_abort) begin
               w_next = S_IDLE;
            end else if (!w_last_h) begin
               w_next = S_RD;
            end else if (!w_last_n) begin
               w_next = S_LATCH;
            end else begin
               w_next = S_FIN;
            end
         end
         S_FIN: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_n              <= '0;
         r_h              <= '0;
         r_upd_weight_old <= '0;
         r_upd_delta      <= '0;
         r_upd_sign       <= 1'b0;
         r_update_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start && !i_abort) begin
                  r_n            <= '0;
                  r_h            <= '0;
                  r_update_count <= '0;
               end
            end
            S_LATCH: begin
               r_upd_delta <= i_delta_in;
               r_upd_sign  <= i_sign_in;
               if (!i_abort && w_skip && !w_last_n) begin
                  r_n <= r_n + NW'(1);
               end
            end
            S_UPD: begin
               r_upd_weight_old <= i_ram_rdata;
            end
            S_WR: begin
               if (r_update_count != 8'hFF) begin
                  r_update_count <= r_update_count + 8'd1;
               end
               if (!i_abort) begin
                  if (!w_last_h) begin
                     r_h <= r_h + HW'(1);
                  end else if (!w_last_n) begin
                     r_h <= '0;
                     r_n <= r_n + NW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_neuron_sel     = r_n;
   assign o_hid_sel        = r_h;
   assign o_upd_weight_old = r_upd_weight_old;
   assign o_upd_delta      = r_upd_delta;
   assign o_upd_sign       = r_upd_sign;
   assign o_update_count   = r_update_count;

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Randomized bench for weight_update_sequencer: a RAM model, a +1 datapath stub and
// a loop-level reference of which weights a pass touches and when it finishes.
module tb_weight_update_sequencer;

   localparam int N_OUT  = 3;
   localparam int N_HID  = 5;
   localparam int W      = 10;
   localparam int ADDR_W = 7;
   localparam int BASE   = 50;
   localparam int NCYC   = 64;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic signed [W-1:0] delta_in;
   logic                sign_in;
   logic [1:0]          neuron_sel;
   logic [2:0]          hid_sel;
   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_re;
   logic signed [W-1:0] ram_rdata = '0;
   logic                ram_we;
   logic signed [W-1:0] ram_wdata;
   logic signed [W-1:0] upd_old;
   logic signed [W-1:0] upd_delta;
   logic                upd_sign;
   logic signed [W-1:0] upd_new;
   logic                busy;
   logic                done;
   logic [7:0]          update_count;

   logic signed [W-1:0] mem     [0:127];
   logic signed [W-1:0] memInit [0:127];
   logic signed [W-1:0] deltas  [0:N_OUT-1];
   logic                signs   [0:N_OUT-1];

   int nVec = 0;
   int nErr = 0;

   // reference-model results
   int                  expReads[$];
   int                  expWAddr[$];
   logic signed [W-1:0] expWData[$];
   int                  expWN[$];
   int                  expWH[$];
   int                  expBusy;
   int                  expDone;
   int                  expCount;
   int                  abortCyc;

   // observations of one pass
   int                  obsReads[$];
   int                  obsWAddr[$];
   logic signed [W-1:0] obsWData[$];
   int                  obsWN[$];
   int                  obsWH[$];
   logic signed [W-1:0] obsWDelta[$];
   logic                obsWSign[$];
   logic signed [W-1:0] obsWOld[$];
   int                  obsDone[$];
   logic                busyAt[0:NCYC-1];
   int                  overlap;

   weight_update_sequencer dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_start          (start),
      .i_abort          (abort),
      .i_delta_in       (delta_in),
      .i_sign_in        (sign_in),
      .o_neuron_sel     (neuron_sel),
      .o_hid_sel        (hid_sel),
      .o_ram_addr       (ram_addr),
      .o_ram_re         (ram_re),
      .i_ram_rdata      (ram_rdata),
      .o_ram_we         (ram_we),
      .o_ram_wdata      (ram_wdata),
      .o_upd_weight_old (upd_old),
      .o_upd_delta      (upd_delta),
      .o_upd_sign       (upd_sign),
      .i_upd_weight_new (upd_new),
      .o_busy           (busy),
      .o_done           (done),
      .o_update_count   (update_count)
   );

   always #5 clk = ~clk;

   assign delta_in = (neuron_sel < 2'(N_OUT)) ? deltas[neuron_sel] : '0;
   assign sign_in  = (neuron_sel < 2'(N_OUT)) ? signs[neuron_sel] : 1'b0;
   assign upd_new  = upd_old + 10'sd1;

   always @(posedge clk) begin
      if (ram_re) ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
   end

   task automatic randomize_setup(input int zeroNeuron);
      for (int a = 0; a < 128; a++) begin
         mem[a] = (a >= BASE && a < BASE + N_OUT * N_HID) ? W'($urandom) : '0;
         memInit[a] = mem[a];
      end
      for (int n = 0; n < N_OUT; n++) begin
         deltas[n] = (n == zeroNeuron) ? '0 : W'($urandom_range(1, 1023));
         signs[n]  = 1'($urandom_range(0, 1));
      end
   endtask

   // kind: 0 = no abort, 1 = abort in the UPD step of (abN, abH), 2 = abort in its WR step
   task automatic build_model(input int kind, input int abN, input int abH);
      int t;
      bit stopped;
      t = 0;
      stopped = 0;
      expReads.delete(); expWAddr.delete(); expWData.delete(); expWN.delete(); expWH.delete();
      expCount = 0;
      abortCyc = -1;
      for (int n = 0; n < N_OUT && !stopped; n++) begin
         t = t + 1;
         if (deltas[n] == 0) continue;
         for (int h = 0; h < N_HID; h++) begin
            int a;
            logic signed [W-1:0] nv;
            a = BASE + n * N_HID + h;
            expReads.push_back(a);
            if (kind == 1 && n == abN && h == abH) begin
               abortCyc = t + 2; t = t + 2; stopped = 1; break;
            end
            nv = memInit[a] + 10'sd1;
            expWAddr.push_back(a); expWData.push_back(nv);
            expWN.push_back(n); expWH.push_back(h);
            expCount++;
            if (kind == 2 && n == abN && h == abH) begin
               abortCyc = t + 3; t = t + 3; stopped = 1; break;
            end
            t = t + 3;
         end
      end
      expBusy = t;
      expDone = stopped ? -1 : t + 1;
   endtask

   task automatic run_and_check_pass(input string name, input bit secondStart);
      obsReads.delete(); obsWAddr.delete(); obsWData.delete(); obsWN.delete(); obsWH.delete();
      obsWDelta.delete(); obsWSign.delete(); obsWOld.delete(); obsDone.delete();
      overlap = 0;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         start = (c == 0) || (secondStart && c == 9);
         abort = (c == abortCyc);
         @(negedge clk);
         busyAt[c] = busy;
         if (done) obsDone.push_back(c);
         if (ram_re) obsReads.push_back(int'(ram_addr));
         if (ram_re && ram_we) overlap++;
         if (ram_we) begin
            obsWAddr.push_back(int'(ram_addr)); obsWData.push_back(ram_wdata);
            obsWN.push_back(int'(neuron_sel)); obsWH.push_back(int'(hid_sel));
            obsWDelta.push_back(upd_delta); obsWSign.push_back(upd_sign); obsWOld.push_back(upd_old);
         end
      end
      start = 1'b0;
      abort = 1'b0;

      nVec++;
      if (obsReads.size() !== expReads.size()) begin
         nErr++; $display("[TB] FAIL %s read_count got %0d want %0d", name, obsReads.size(), expReads.size());
      end
      for (int i = 0; i < obsReads.size() && i < expReads.size(); i++) begin
         nVec++;
         if (obsReads[i] !== expReads[i]) begin
            nErr++; $display("[TB] FAIL %s read_addr[%0d] got %0d want %0d", name, i, obsReads[i], expReads[i]);
         end
      end
      nVec++;
      if (obsWAddr.size() !== expWAddr.size()) begin
         nErr++; $display("[TB] FAIL %s write_count got %0d want %0d", name, obsWAddr.size(), expWAddr.size());
      end
      for (int i = 0; i < obsWAddr.size() && i < expWAddr.size(); i++) begin
         int n;
         n = expWN[i];
         nVec++;
         if (obsWAddr[i] !== expWAddr[i] || obsWData[i] !== expWData[i]) begin
            nErr++; $display("[TB] FAIL %s write[%0d] got addr %0d data %0d want addr %0d data %0d",
                             name, i, obsWAddr[i], obsWData[i], expWAddr[i], expWData[i]);
         end
         nVec++;
         if (obsWN[i] !== n || obsWH[i] !== expWH[i]) begin
            nErr++; $display("[TB] FAIL %s sel[%0d] got n%0d h%0d want n%0d h%0d",
                             name, i, obsWN[i], obsWH[i], n, expWH[i]);
         end
         nVec++;
         if (obsWDelta[i] !== deltas[n] || obsWSign[i] !== signs[n] || obsWOld[i] !== memInit[expWAddr[i]]) begin
            nErr++; $display("[TB] FAIL %s dp_in[%0d] got d%0d s%0b old%0d want d%0d s%0b old%0d", name, i,
                             obsWDelta[i], obsWSign[i], obsWOld[i], deltas[n], signs[n], memInit[expWAddr[i]]);
         end
      end
      nVec++;
      if (expDone < 0) begin
         if (obsDone.size() !== 0) begin
            nErr++; $display("[TB] FAIL %s done_pulses got %0d want 0", name, obsDone.size());
         end
      end else if (obsDone.size() !== 1 || obsDone[0] !== expDone) begin
         nErr++; $display("[TB] FAIL %s done_cycle got %0d pulses first at %0d want 1 pulse at %0d",
                          name, obsDone.size(), (obsDone.size() > 0) ? obsDone[0] : -1, expDone);
      end
      for (int c = 0; c < NCYC; c++) begin
         logic eb;
         eb = (c >= 1 && c <= expBusy);
         nVec++;
         if (busyAt[c] !== eb) begin
            nErr++; $display("[TB] FAIL %s busy@%0d got %0b want %0b", name, c, busyAt[c], eb);
         end
      end
      nVec++;
      if (int'(update_count) !== expCount) begin
         nErr++; $display("[TB] FAIL %s update_count got %0d want %0d", name, update_count, expCount);
      end
      nVec++;
      if (overlap !== 0) begin
         nErr++; $display("[TB] FAIL %s re_we_overlap got %0d want 0", name, overlap);
      end
   endtask

   task automatic test_reset();
      #3;
      nVec++;
      if ({busy, done, ram_re, ram_we, ram_addr, ram_wdata, upd_old, upd_delta, upd_sign, update_count, neuron_sel, hid_sel} !== '0) begin
         nErr++; $display("[TB] FAIL reset_outputs got busy%0b done%0b re%0b we%0b addr%0d cnt%0d want all zero",
                          busy, done, ram_re, ram_we, ram_addr, update_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_default_pass();
      randomize_setup(-1);
      build_model(0, 0, 0);
      run_and_check_pass("default_pass", 1'b0);
   endtask

   task automatic test_skip_zero();
      randomize_setup(1);
      build_model(0, 0, 0);
      run_and_check_pass("skip_zero", 1'b0);
   endtask

   task automatic test_abort_upd();
      randomize_setup(-1);
      build_model(1, 1, 2);
      run_and_check_pass("abort_upd", 1'b0);
   endtask

   task automatic test_abort_wr();
      randomize_setup(-1);
      build_model(2, 0, 2);
      run_and_check_pass("abort_wr", 1'b0);
   endtask

   task automatic test_start_abort_idle();
      int strobes;
      int busyCyc;
      strobes = 0;
      busyCyc = 0;
      @(posedge clk);
      #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (busy) busyCyc++;
         if (ram_re || ram_we) strobes++;
      end
      nVec++;
      if (busyCyc !== 0 || strobes !== 0) begin
         nErr++; $display("[TB] FAIL start_abort_idle got busy_cycles %0d strobes %0d want 0 0", busyCyc, strobes);
      end
   endtask

   task automatic test_back_to_back();
      randomize_setup(-1);
      build_model(0, 0, 0);
      run_and_check_pass("second_start_busy", 1'b1);
   endtask

   task automatic test_reset_mid_pass();
      int strobes;
      int busyCyc;
      strobes = 0;
      busyCyc = 0;
      randomize_setup(-1);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      nVec++;
      if (ram_re !== 1'b1) begin
         nErr++; $display("[TB] FAIL reset_mid_pass_rd got re %0b want 1", ram_re);
      end
      #2;
      rst_n = 1'b0;
      #1;
      nVec++;
      if ({busy, done, ram_re, ram_we, ram_addr, ram_wdata, upd_old, upd_delta, upd_sign, update_count, neuron_sel, hid_sel} !== '0) begin
         nErr++; $display("[TB] FAIL reset_mid_pass_outputs got busy%0b re%0b addr%0d delta%0d cnt%0d want all zero",
                          busy, ram_re, ram_addr, upd_delta, update_count);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy) busyCyc++;
         if (ram_re || ram_we) strobes++;
      end
      nVec++;
      if (busyCyc !== 0 || strobes !== 0) begin
         nErr++; $display("[TB] FAIL reset_mid_pass_after got busy_cycles %0d strobes %0d want 0 0", busyCyc, strobes);
      end
   endtask

   initial begin
      for (int n = 0; n < N_OUT; n++) begin
         deltas[n] = '0;
         signs[n]  = 1'b0;
      end
      for (int a = 0; a < 128; a++) begin
         mem[a] = '0;
         memInit[a] = '0;
      end
      test_reset();
      test_default_pass();
      test_skip_zero();
      test_abort_upd();
      test_abort_wr();
      test_start_abort_idle();
      test_back_to_back();
      test_reset_mid_pass();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
